// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster timing generator with frame-synchronous pattern-mode handshake.
//   clock       : system clock, all logic on the rising edge
//   reset_n     : synchronous active-low reset
//   mode_req    : 4-phase mode change request
//   mode_in     : requested pattern mode, stable while mode_req is high
//   mode_ack    : mode_in has been applied
//   mode        : active pattern mode
//   pxcount     : horizontal pixel position
//   linecount   : vertical line position
//   bright      : active video region
//   hsync/vsync : active-low sync pulses
//   frame_start : one-clock pulse as the raster wraps to (0,0)
//   frame_count : completed-frame counter
module vga_timing_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        mode_req,
  input  logic [1:0]  mode_in,
  output logic        mode_ack,
  output logic [1:0]  mode,
  output logic [10:0] pxcount,
  output logic [10:0] linecount,
  output logic        bright,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic [7:0]  frame_count
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE - 1);
  localparam logic [10:0] H_FP_END   = 11'(H_ACTIVE + H_FP - 1);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE - 1);
  localparam logic [10:0] V_FP_END   = 11'(V_ACTIVE + V_FP - 1);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);

  typedef enum logic [1:0] {S_HACT, S_HFP, S_HSYNC, S_HBP} h_state_t;
  typedef enum logic [1:0] {S_VACT, S_VFP, S_VSYNC, S_VBP} v_state_t;
  typedef enum logic [1:0] {M_IDLE, M_PEND, M_ACK} m_state_t;

  logic [3:0] divider;
  logic       tick, line_end, frame_end;
  h_state_t   h_state, h_next;
  v_state_t   v_state, v_next;
  m_state_t   m_state, m_next;
  logic       hsync_d, vsync_d, bright_d;
  logic [1:0] pending;
  logic       capture, apply;

  assign tick      = divider == 4'(CLK_DIV - 1);
  assign line_end  = tick && pxcount == H_LAST;
  assign frame_end = line_end && linecount == V_LAST;

  always_ff @(posedge clock)
    if (!reset_n) begin
      divider     <= '0;
      pxcount     <= '0;
      linecount   <= '0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      divider     <= tick ? '0 : divider + 4'd1;
      pxcount     <= !tick ? pxcount : line_end ? '0 : pxcount + 11'd1;
      linecount   <= !line_end ? linecount : frame_end ? '0 : linecount + 11'd1;
      frame_start <= frame_end;
      frame_count <= frame_end ? frame_count + 8'd1 : frame_count;
    end

  // Sync/blank outputs are registered from the next state so they change on
  // the same edge as the counters they describe.
  always_ff @(posedge clock)
    if (!reset_n) begin
      h_state <= S_HACT;
      v_state <= S_VACT;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      bright  <= 1'b0;
    end else begin
      h_state <= h_next;
      v_state <= v_next;
      hsync   <= hsync_d;
      vsync   <= vsync_d;
      bright  <= bright_d;
    end

  always_comb begin
    h_next = h_state;
    if (tick)
      case (h_state)
        S_HACT:  h_next = pxcount == H_ACT_END  ? S_HFP   : S_HACT;
        S_HFP:   h_next = pxcount == H_FP_END   ? S_HSYNC : S_HFP;
        S_HSYNC: h_next = pxcount == H_SYNC_END ? S_HBP   : S_HSYNC;
        default: h_next = pxcount == H_LAST     ? S_HACT  : S_HBP;
      endcase
  end

  always_comb begin
    v_next = v_state;
    if (line_end)
      case (v_state)
        S_VACT:  v_next = linecount == V_ACT_END  ? S_VFP   : S_VACT;
        S_VFP:   v_next = linecount == V_FP_END   ? S_VSYNC : S_VFP;
        S_VSYNC: v_next = linecount == V_SYNC_END ? S_VBP   : S_VSYNC;
        default: v_next = linecount == V_LAST     ? S_VACT  : S_VBP;
      endcase
  end

  always_comb begin
    hsync_d  = h_next != S_HSYNC;
    vsync_d  = v_next != S_VSYNC;
    bright_d = h_next == S_HACT && v_next == S_VACT;
  end

  always_ff @(posedge clock)
    if (!reset_n) m_state <= M_IDLE;
    else          m_state <= m_next;

  // A capture on the frame_end edge lands in M_PEND after that edge, so the
  // mode is applied at the following frame boundary, never the current one.
  always_comb begin
    m_next = m_state;
    case (m_state)
      M_IDLE:  m_next = capture ? M_PEND : M_IDLE;
      M_PEND:  m_next = frame_end ? M_ACK : M_PEND;
      M_ACK:   m_next = mode_req ? M_ACK : M_IDLE;
      default: m_next = M_IDLE;
    endcase
  end

  always_comb begin
    mode_ack = m_state == M_ACK;
    capture  = m_state == M_IDLE && mode_req && !mode_ack;
    apply    = m_state == M_PEND && frame_end;
  end

  always_ff @(posedge clock)
    if (!reset_n) begin
      pending <= '0;
      mode    <= '0;
    end else begin
      pending <= capture ? mode_in : pending;
      mode    <= apply ? pending : mode;
    end
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: self-checking bench for vga_timing_ctrl on a shrunken raster.
module tb_vga_timing_ctrl;
  localparam int CD = 3;
  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int FC = FT * CD;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        mode_req = 1'b0;
  logic [1:0]  mode_in = 2'd0;
  logic        mode_ack;
  logic [1:0]  mode;
  logic [10:0] pxcount, linecount;
  logic        bright, hsync, vsync, frame_start;
  logic [7:0]  frame_count;
  logic [36:0] dut_v;

  always #5 clock = ~clock;

  vga_timing_ctrl #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clock(clock), .reset_n(reset_n), .mode_req(mode_req), .mode_in(mode_in),
    .mode_ack(mode_ack), .mode(mode), .pxcount(pxcount), .linecount(linecount),
    .bright(bright), .hsync(hsync), .vsync(vsync), .frame_start(frame_start),
    .frame_count(frame_count)
  );

  assign dut_v = {mode_ack, mode, pxcount, linecount, bright, hsync, vsync, frame_start, frame_count};

  int checks = 0, errors = 0;
  int k = 0;
  logic mp = 1'b0, ma = 1'b0;
  logic [1:0] mm = 2'd0, pv = 2'd0;

  typedef struct {
    int          k;
    logic [10:0] px, ln;
    logic        br, hs, vs, fs;
    logic [7:0]  fc;
  } vec_t;
  vec_t tbl[15];

  // Raster position follows from the number of completed pixel ticks since release.
  function automatic logic [36:0] expv();
    int t, px, ln;
    logic br, hs, vs, fs;
    t  = k / CD;
    px = t % HT;
    ln = (t / HT) % VT;
    br = k > 0 && px < HA && ln < VA;
    hs = !(px >= HA + HF && px < HA + HF + HS);
    vs = !(ln >= VA + VF && ln < VA + VF + VS);
    fs = k > 0 && k % CD == 0 && t % FT == 0;
    return {ma, mm, 11'(px), 11'(ln), br, hs, vs, fs, 8'((t / FT) % 256)};
  endfunction

  task automatic chk(input string nm, input logic [36:0] got, input logic [36:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic cycle();
    logic fsn;
    @(posedge clock);
    if (!reset_n) begin
      k = 0; mp = 1'b0; ma = 1'b0; mm = 2'd0; pv = 2'd0;
    end else begin
      k++;
      fsn = k % CD == 0 && (k / CD) % FT == 0;
      if (ma) begin
        if (!mode_req) ma = 1'b0;
      end else if (mp) begin
        if (fsn) begin mm = pv; ma = 1'b1; mp = 1'b0; end
      end else if (mode_req) begin
        mp = 1'b1; pv = mode_in;
      end
    end
    @(negedge clock);
    chk($sformatf("cycle k=%0d", k), dut_v, expv());
  endtask

  task automatic wait_fs(input string nm, output int n);
    n = 0;
    do begin cycle(); n++; end while (frame_start !== 1'b1 && n < 2 * FC);
    chk({nm, " fs timeout"}, 37'(frame_start), 37'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    int n, g, fs_cnt, br_c, hs_c, vs_c, per_c;
    logic sticky;
    tbl[0]  = '{0,   11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[1]  = '{1,   11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[2]  = '{3,   11'd1, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[3]  = '{12,  11'd4, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[4]  = '{15,  11'd5, 11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[5]  = '{20,  11'd6, 11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[6]  = '{21,  11'd7, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[7]  = '{24,  11'd0, 11'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[8]  = '{72,  11'd0, 11'd3, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[9]  = '{96,  11'd0, 11'd4, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[10] = '{144, 11'd0, 11'd6, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[11] = '{167, 11'd7, 11'd6, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[12] = '{168, 11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1};
    tbl[13] = '{169, 11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[14] = '{171, 11'd1, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1};

    reset_n = 1'b0;
    cycle();
    do_reset();
    foreach (tbl[i]) begin
      while (k < tbl[i].k) cycle();
      chk($sformatf("tbl%0d", i),
          37'({pxcount, linecount, bright, hsync, vsync, frame_start, frame_count}),
          37'({tbl[i].px, tbl[i].ln, tbl[i].br, tbl[i].hs, tbl[i].vs, tbl[i].fs, tbl[i].fc}));
    end

    // Mid-frame request is held until the next frame boundary.
    g = 0;
    while (linecount != 11'd2 && g < FC) begin cycle(); g++; end
    mode_in = 2'd2; mode_req = 1'b1;
    cycle();
    chk("req mid hold", 37'(mode), 37'd0);
    wait_fs("req mid", n);
    chk("req mid mode", 37'({mode_ack, mode}), 37'({1'b1, 2'd2}));
    mode_req = 1'b0;
    cycle();
    chk("req mid ack drop", 37'({mode_ack, mode}), 37'({1'b0, 2'd2}));

    // Request raised while frame_start is high waits a whole frame.
    wait_fs("req on fs a", n);
    mode_in = 2'd1; mode_req = 1'b1;
    cycle();
    chk("req on fs hold", 37'({mode_ack, mode}), 37'({1'b0, 2'd2}));
    wait_fs("req on fs b", n);
    chk("req on fs period", 37'(n), 37'(FC - 1));
    chk("req on fs mode", 37'({mode_ack, mode}), 37'({1'b1, 2'd1}));
    mode_req = 1'b0;
    cycle();
    chk("req on fs ack drop", 37'(mode_ack), 37'd0);

    // Capture on the very edge that produces frame_start.
    g = 0;
    while (!((k + 1) % CD == 0 && ((k + 1) / CD) % FT == 0) && g < FC) begin cycle(); g++; end
    mode_in = 2'd3; mode_req = 1'b1;
    cycle();
    chk("capture at fs", 37'({frame_start, mode_ack, mode}), 37'({1'b1, 1'b0, 2'd1}));
    wait_fs("capture at fs next", n);
    chk("capture at fs mode", 37'({mode_ack, mode}), 37'({1'b1, 2'd3}));
    mode_req = 1'b0;
    cycle();

    // Protocol violation: req dropped while pending is still applied.
    mode_in = 2'd0; mode_req = 1'b1;
    cycle();
    mode_req = 1'b0;
    wait_fs("violation", n);
    chk("violation mode", 37'({mode_ack, mode}), 37'({1'b1, 2'd0}));
    cycle();
    chk("violation ack drop", 37'(mode_ack), 37'd0);

    // Reset mid-frame while a request is pending.
    g = 0;
    while (linecount != 11'd2 && g < FC) begin cycle(); g++; end
    mode_in = 2'd2; mode_req = 1'b1;
    cycle(); cycle();
    reset_n = 1'b0; mode_req = 1'b0;
    cycle();
    chk("reset values", dut_v, {1'b0, 2'd0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0});
    reset_n = 1'b1;
    sticky = 1'b0;
    repeat (2 * FC) begin
      cycle();
      if (mode_ack || mode != 2'd0) sticky = 1'b1;
    end
    chk("reset no ack", 37'(sticky), 37'd0);

    // Randomized handshake traffic against the model.
    repeat (20 * FC) begin
      if (!mode_req) begin
        if (!mode_ack && $urandom_range(0, 15) == 0) begin
          mode_in = 2'($urandom_range(0, 3)); mode_req = 1'b1;
        end
      end else if (mode_ack) begin
        if ($urandom_range(0, 3) == 0) mode_req = 1'b0;
      end else if ($urandom_range(0, 199) == 0) mode_req = 1'b0;
      cycle();
    end
    mode_req = 1'b0;

    // 256 frames from reset with per-frame region measurements.
    do_reset();
    fs_cnt = 0; n = 0; br_c = 0; hs_c = 0; vs_c = 0; per_c = 0;
    while (fs_cnt < 256 && n < 256 * FC + 10) begin
      cycle();
      n++;
      if (frame_start) begin
        fs_cnt++;
        if (fs_cnt == 2) begin
          chk("bright per frame", 37'(br_c), 37'(HA * VA * CD));
          chk("hsync low per frame", 37'(hs_c), 37'(VT * HS * CD));
          chk("vsync low per frame", 37'(vs_c), 37'(VS * HT * CD));
          chk("frame period", 37'(per_c), 37'(FC));
        end
        br_c = 0; hs_c = 0; vs_c = 0; per_c = 0;
      end
      br_c += int'(bright);
      hs_c += int'(!hsync);
      vs_c += int'(!vsync);
      per_c++;
    end
    chk("256 frames count", 37'(fs_cnt), 37'd256);
    chk("256 frames cycles", 37'(n), 37'(256 * FC));
    chk("frame_count wrap", 37'(frame_count), 37'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 4, system clocks per pixel tick; legal values are 2..16.
REQ-002 Parameter H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48, horizontal region lengths in pixel ticks; H_TOTAL = 800.
REQ-003 Parameter V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, vertical region lengths in lines; V_TOTAL = 525.
REQ-004 clock  input  1  single system clock; all logic is on the rising edge.
REQ-005 reset_n  input  1  reset; synchronous, active-low.
REQ-006 mode_req  input  1  pattern-mode change request, 4-phase handshake.
REQ-007 mode_in  input  2  requested pattern mode; must be stable while mode_req is high.
REQ-008 mode_ack  output  1  acknowledges that mode_in has been applied.
REQ-009 mode  output  2  active pattern mode, for downstream colour logic.
REQ-010 pxcount  output  11  horizontal pixel position, 0..H_TOTAL-1.
REQ-011 linecount  output  11  vertical line position, 0..V_TOTAL-1.
REQ-012 bright  output  1  high in the active video region; feeds colorgen's bright input.
REQ-013 hsync  output  1  horizontal sync, active-low.
REQ-014 vsync  output  1  vertical sync, active-low.
REQ-015 frame_start  output  1  one-clock pulse at the start of each frame.
REQ-016 frame_count  output  8  completed-frame counter.

Function
REQ-017 The divider SHALL count 0..CLK_DIV-1; tick is asserted for the one clock where divider == CLK_DIV-1.
REQ-018 pxcount SHALL increment only on tick, and SHALL wrap from H_TOTAL-1 to 0.
REQ-019 linecount SHALL increment only on a tick where pxcount wraps, and SHALL wrap from V_TOTAL-1 to 0.
REQ-020 The horizontal FSM SHALL have states H_ACT, H_FP, H_SYNC, H_BP, advancing on tick at region boundaries:
- H_ACT: px 0..639
- H_FP: px 640..655
- H_SYNC: px 656..751
- H_BP: px 752..799
REQ-021 The vertical FSM SHALL have states V_ACT, V_FP, V_SYNC, V_BP, advancing on line wrap:
- V_ACT: lines 0..479
- V_FP: lines 480..489
- V_SYNC: lines 490..491
- V_BP: lines 492..524
REQ-022 hsync, vsync and bright SHALL be registered and consistent with the pxcount/linecount values presented in the same clock.
REQ-023 hsync SHALL be low iff the horizontal FSM is in H_SYNC; vsync SHALL be low iff the vertical FSM is in V_SYNC.
REQ-024 bright SHALL be high iff the FSMs are in H_ACT and V_ACT.
REQ-025 Downstream colour logic adds one register stage, so rgb lags bright by one clock; this block SHALL NOT compensate for that lag.
REQ-026 frame_start SHALL pulse for exactly one clock, on the clock where pxcount and linecount both become 0 from a wrap.
REQ-027 frame_count SHALL increment on that same clock, wrapping from 255 to 0.
REQ-028 Mode FSM states are M_IDLE, M_PEND and M_ACK.
REQ-029 In M_IDLE with mode_req high and mode_ack low, the block SHALL capture mode_in into a pending register and enter M_PEND.
REQ-030 In M_PEND, on the frame_start clock, the block SHALL load mode from the pending register, set mode_ack high and enter M_ACK; mode changes only at frame boundaries.
REQ-031 In M_ACK, mode_ack SHALL stay high until mode_req is seen low, then drop the next clock and the FSM returns to M_IDLE.
REQ-032 A new request SHALL NOT be accepted while mode_ack is high.
REQ-033 If the capture clock coincides with frame_start, the mode SHALL be applied at the next frame start, not the current one.
REQ-034 If mode_req drops while in M_PEND (protocol violation), the pending mode SHALL still be applied and acknowledged, and mode_ack SHALL then drop on the following clock.

Reset
REQ-035 While reset_n is low at a clock edge, every register SHALL be set to the values below, including mid-frame and mid-handshake:
- divider = 0, pxcount = 0, linecount = 0
- FSMs in H_ACT, V_ACT, M_IDLE
- hsync = 1, vsync = 1, bright = 0
- frame_start = 0, frame_count = 0
- mode = 0, mode_ack = 0
- pending mode discarded
REQ-036 After reset release, the first tick SHALL occur CLK_DIV clocks after the release edge, and bright SHALL go high on that first clock after release.

Verification
REQ-037 Free run from reset, CLK_DIV = 4 -> hsync low for exactly 384 clocks per 3200-clock line; vsync low for exactly 2 lines (6400 clocks); frame period 1,680,000 clocks.
REQ-038 Boundary check -> px 639→640 drops bright; px 655→656 drops hsync; px 751→752 raises hsync; px 799 wraps to 0 with linecount+1; line 524 wraps to 0 with frame_start = 1 and frame_count+1.
REQ-039 Raise mode_req with mode_in = 2 mid-frame -> mode stays 0 until the next frame_start, where mode = 2 and mode_ack = 1; drop req -> ack drops on the next clock.
REQ-040 Raise req on the frame_start clock -> mode unchanged at that frame start; mode applied one full frame later.
REQ-041 Pulse reset_n low at line 300 during M_PEND -> all outputs take their reset values the next clock; no ack or mode change follows.
REQ-042 Run 256 frames -> frame_count returns to 0; bright high count per frame = 307,200 ticks.
